// File: rtl/bus_arbiter.sv
// Four-master round-robin arbiter for a shared bus; the owner's bus signals
// pass through combinationally and only the owner sees the slave's ready.
// Ports: clk, reset (async, active-low); mN_req_/mN_grnt_ (active-low);
// mN_addr/as_/rw/wr_data in; mN_rdy_ out; s_* shared bus; owner, busy.
module bus_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_,
  input  logic              m1_req_,
  input  logic              m2_req_,
  input  logic              m3_req_,
  output logic              m0_grnt_,
  output logic              m1_grnt_,
  output logic              m2_grnt_,
  output logic              m3_grnt_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic [ADDR_W-1:0] m3_addr,
  input  logic              m0_as_,
  input  logic              m1_as_,
  input  logic              m2_as_,
  input  logic              m3_as_,
  input  logic              m0_rw,
  input  logic              m1_rw,
  input  logic              m2_rw,
  input  logic              m3_rw,
  input  logic [DATA_W-1:0] m0_wr_data,
  input  logic [DATA_W-1:0] m1_wr_data,
  input  logic [DATA_W-1:0] m2_wr_data,
  input  logic [DATA_W-1:0] m3_wr_data,
  output logic              m0_rdy_,
  output logic              m1_rdy_,
  output logic              m2_rdy_,
  output logic              m3_rdy_,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_as_,
  output logic              s_rw,
  output logic [DATA_W-1:0] s_wr_data,
  input  logic              s_rdy_,
  output logic [1:0]        owner,
  output logic              busy
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;

  logic [3:0]        req;
  logic [3:0]        as_n;
  logic [3:0]        rw;
  logic [ADDR_W-1:0] addr [4];
  logic [DATA_W-1:0] wdat [4];

  assign req  = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign as_n = {m3_as_, m2_as_, m1_as_, m0_as_};
  assign rw   = {m3_rw, m2_rw, m1_rw, m0_rw};
  assign addr = '{m0_addr, m1_addr, m2_addr, m3_addr};
  assign wdat = '{m0_wr_data, m1_wr_data,
                  m2_wr_data, m3_wr_data};

  // Circular search from last+1; last itself is visited at k=4.
  logic       found;
  logic [1:0] win;
  logic [1:0] idx;

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWNED;
          owner_d = win;
          last_d  = win;
        end
      end
      OWNED: begin
        // Owner's request is inactive here, so it cannot be the winner.
        if (!req[owner_q]) begin
          if (found) begin
            owner_d = win;
            last_d  = win;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  logic       own;
  logic [3:0] sel;
  logic [3:0] grnt_n;
  logic [3:0] rdy_n;

  assign own    = (state_q == OWNED);
  assign sel    = own ? (4'b0001 << owner_q) : 4'b0000;
  assign grnt_n = ~sel;
  assign rdy_n  = s_rdy_ ? 4'hF : ~sel;

  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_n;
  assign {m3_rdy_, m2_rdy_, m1_rdy_, m0_rdy_}     = rdy_n;

  assign s_addr    = own ? addr[owner_q] : '0;
  assign s_as_     = own ? as_n[owner_q] : 1'b1;
  assign s_rw      = own ? rw[owner_q]   : 1'b1;
  assign s_wr_data = own ? wdat[owner_q] : '0;

  assign owner = owner_q;
  assign busy  = own;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed request sequences push the
// expected owner per cycle; a monitor compares after each rising edge.
module tb_bus_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    req_n = 4'hF;
  logic [3:0]    as_n = 4'h0;
  logic [3:0]    rw = 4'b1010;
  logic          s_rdy_n = 1'b1;
  logic [AW-1:0] addr [4];
  logic [DW-1:0] wd [4];

  logic [3:0]    grnt_n;
  logic [3:0]    rdy_n;
  logic [AW-1:0] s_addr;
  logic          s_as_;
  logic          s_rw;
  logic [DW-1:0] s_wr_data;
  logic [1:0]    owner;
  logic          busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) begin
      addr[i] = AW'(32'h100 * (i + 1));
      wd[i]   = 32'hD000_0000 + i;
    end
  end

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]),
    .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_grnt_(grnt_n[0]), .m1_grnt_(grnt_n[1]),
    .m2_grnt_(grnt_n[2]), .m3_grnt_(grnt_n[3]),
    .m0_addr(addr[0]), .m1_addr(addr[1]),
    .m2_addr(addr[2]), .m3_addr(addr[3]),
    .m0_as_(as_n[0]), .m1_as_(as_n[1]),
    .m2_as_(as_n[2]), .m3_as_(as_n[3]),
    .m0_rw(rw[0]), .m1_rw(rw[1]),
    .m2_rw(rw[2]), .m3_rw(rw[3]),
    .m0_wr_data(wd[0]), .m1_wr_data(wd[1]),
    .m2_wr_data(wd[2]), .m3_wr_data(wd[3]),
    .m0_rdy_(rdy_n[0]), .m1_rdy_(rdy_n[1]),
    .m2_rdy_(rdy_n[2]), .m3_rdy_(rdy_n[3]),
    .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw),
    .s_wr_data(s_wr_data), .s_rdy_(s_rdy_n),
    .owner(owner), .busy(busy)
  );

  typedef struct {
    string         name;
    logic [3:0]    grnt;
    logic          busy;
    logic [1:0]    owner;
    logic          as_n;
    logic          rw;
    logic [3:0]    rdy;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t q[$];

  task automatic chk(string n, logic [127:0] got,
                     logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, got, exp);
    end
  endtask

  // Monitor: one expected snapshot per cycle after the rising edge.
  initial begin
    exp_t e;
    logic [1:0] o;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        o = e.busy ? owner : e.owner;
        chk(e.name,
            {grnt_n, busy, o, s_as_, s_rw, rdy_n, s_addr, s_wr_data},
            {e.grnt, e.busy, e.owner, e.as_n, e.rw, e.rdy,
             e.addr, e.wd});
      end
    end
  end

  // own < 0 means IDLE expected for the cycle after the next edge.
  task automatic step(string n, int own);
    exp_t e;
    e.name  = n;
    e.busy  = (own >= 0);
    e.owner = e.busy ? 2'(own) : 2'd0;
    if (e.busy) begin
      e.grnt = ~(4'b0001 << e.owner);
      e.as_n = as_n[e.owner];
      e.rw   = rw[e.owner];
      e.addr = addr[e.owner];
      e.wd   = wd[e.owner];
      e.rdy  = s_rdy_n ? 4'hF : e.grnt;
    end else begin
      e.grnt = 4'hF;
      e.as_n = 1'b1;
      e.rw   = 1'b1;
      e.addr = '0;
      e.wd   = '0;
      e.rdy  = 4'hF;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    req_n   = 4'hF;
    s_rdy_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2;
    chk("reset_state",
        {grnt_n, busy, owner, s_as_, rdy_n},
        {4'hF, 1'b0, 2'd0, 1'b1, 4'hF});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single requester m2.
    req_n = 4'b1011;
    step("m2_grant", 2);
    step("m2_hold", 2);
    req_n = 4'hF;
    step("m2_idle", -1);

    // All four request; each releases for one cycle.
    do_reset();
    req_n = 4'h0;
    step("rr0_a", 0);
    step("rr0_b", 0);
    req_n = 4'b0001;
    step("rr1_a", 1);
    req_n = 4'h0;
    step("rr1_b", 1);
    req_n = 4'b0010;
    step("rr2_a", 2);
    req_n = 4'h0;
    step("rr2_b", 2);
    req_n = 4'b0100;
    step("rr3_a", 3);
    req_n = 4'h0;
    step("rr3_b", 3);
    req_n = 4'b1000;
    step("rr0_wrap", 0);
    req_n = 4'h0;
    step("rr0_wrap_b", 0);
    req_n = 4'hF;
    step("rr_idle", -1);

    // No preemption of m1 by m0/m3.
    do_reset();
    req_n = 4'b1101;
    step("m1_only", 1);
    req_n = 4'b0100;
    for (int i = 0; i < 9; i++) step("m1_holds", 1);
    req_n = 4'b0110;
    step("m3_after_m1", 3);
    req_n = 4'b1110;
    step("m0_after_m3", 0);
    req_n = 4'hF;
    step("np_idle", -1);

    // Release to idle, then re-request (last = 0).
    req_n = 4'b1101;
    step("m1_req", 1);
    req_n   = 4'hF;
    s_rdy_n = 1'b0;
    step("m1_rel_idle", -1);
    s_rdy_n = 1'b1;
    req_n   = 4'b1101;
    step("m1_regrant", 1);

    // Ready routing with m2 owning.
    req_n = 4'hF;
    step("rdy_idle", -1);
    req_n = 4'b1011;
    step("m2_own", 2);
    s_rdy_n = 1'b0;
    step("m2_rdy_lo", 2);
    s_rdy_n = 1'b1;
    step("m2_rdy_hi", 2);
    s_rdy_n = 1'b0;
    step("m2_rdy_lo2", 2);
    s_rdy_n = 1'b1;

    // Async reset while m3 owns with s_as_ low.
    req_n = 4'b0111;
    step("m3_own", 3);
    #2;
    chk("m3_as_low", {28'd0, s_as_}, 29'd0);
    reset = 1'b0;
    #1;
    chk("async_rst",
        {grnt_n, busy, s_as_, rdy_n},
        {4'hF, 1'b0, 1'b1, 4'hF});
    req_n = 4'b0110;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step("m0_first", 0);
    req_n = 4'hF;
    step("end_idle", -1);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
